// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: Wishbone classic single-transfer initiator.
// Each command on the cmd_* stream becomes one Wishbone read or write, and its
// result is returned on the rsp_* stream. At most one transfer is outstanding.
// Optional feature: define WBM_TIMEOUT_EN to abort a bus cycle that is not
// acknowledged within TIMEOUT_CYCLES cycles (response then carries rsp_err = 1).
`timescale 1ns/1ps
module wb_cmd_initiator #(
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   // command stream
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [DW/8-1:0]   cmd_sel,
   input  logic [AW-1:0]     cmd_adr,
   input  logic [DW-1:0]     cmd_dat,
   // response stream
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_dat,
   output logic              rsp_err,
   // Wishbone initiator port
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [DW/8-1:0]   wbm_sel_o,
   output logic [AW-1:0]     wbm_adr_o,
   output logic [DW-1:0]     wbm_dat_o,
   input  logic              wbm_ack_i,
   input  logic [DW-1:0]     wbm_dat_i,
   // status
   output logic              busy
);

   localparam int unsigned SW = DW / 8;

   // Reject an illegal timeout setting at elaboration.
   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_cmd_initiator: TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q,     state_d;
   logic            cyc_q,       cyc_d;
   logic            stb_q,       stb_d;
   logic            we_q,        we_d;
   logic [SW-1:0]   sel_q,       sel_d;
   logic [AW-1:0]   adr_q,       adr_d;
   logic [DW-1:0]   dat_q,       dat_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_dat_q,   rsp_dat_d;

`ifdef WBM_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   // Counter value seen on the last allowed BUS cycle.
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0]   tmo_cnt_q,   tmo_cnt_d;
   logic            rsp_err_q,   rsp_err_d;
`endif

   // Next-state and next-output computation for the transfer sequencer.
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
`ifdef WBM_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      rsp_err_d   = rsp_err_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = S_BUS;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = cmd_we;
               sel_d   = cmd_sel;
               adr_d   = cmd_adr;
               // Reads drive a zero data bus.
               dat_d   = cmd_we ? cmd_dat : '0;
`ifdef WBM_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end

         S_BUS: begin
            if (wbm_ack_i) begin
               state_d     = S_RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               sel_d       = '0;
               adr_d       = '0;
               dat_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = we_q ? '0 : wbm_dat_i;
`ifdef WBM_TIMEOUT_EN
               rsp_err_d   = 1'b0;
            end else if (tmo_cnt_q == TMO_LAST) begin
               // No ack on the last allowed cycle: abort the bus cycle.
               state_d     = S_RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               sel_d       = '0;
               adr_d       = '0;
               dat_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = '0;
               rsp_err_d   = 1'b1;
            end else begin
               tmo_cnt_d   = tmo_cnt_q + CW'(1);
`endif
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_dat_d   = '0;
`ifdef WBM_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; synchronous reset drops any in-flight command.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= S_IDLE;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
`ifdef WBM_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
`ifdef WBM_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   // Output mapping.
   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
`ifdef WBM_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Testbench for wb_cmd_initiator: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural Wishbone slave.
`timescale 1ns/1ps
module tb_wb_cmd_initiator;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 16;

   logic          clk;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [3:0]    cmd_sel;
   logic [31:0]   cmd_adr, cmd_dat;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [31:0]   rsp_dat;
   logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]    wbm_sel_o;
   logic [31:0]   wbm_adr_o, wbm_dat_o;
   logic          wbm_ack_i;
   logic [31:0]   wbm_dat_i;
   logic          busy;

   // Slave: either driven by hand from the tasks or by the automatic model.
   logic          ack_man, ack_auto, slave_auto;
   logic [31:0]   dat_man, dat_auto;
   int            slave_lat;
   int            wcnt;

   int            checks = 0;
   int            errors = 0;
   int            stab_viol = 0;

   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } bus_t;

   bus_t          bus_log[$];
   bus_t          cur_bus, prev_bus;
   logic          prev_cyc;

   assign wbm_ack_i = ack_man | ack_auto;
   assign wbm_dat_i = ack_auto ? dat_auto : dat_man;
   assign cur_bus   = {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o};

   wb_cmd_initiator #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_sel   (cmd_sel),
      .cmd_adr   (cmd_adr),
      .cmd_dat   (cmd_dat),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dat   (rsp_dat),
      .rsp_err   (rsp_err),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_i (wbm_ack_i),
      .wbm_dat_i (wbm_dat_i),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read data the slave returns for a given address.
   function automatic logic [31:0] rd_func(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   // Automatic slave: registered ack slave_lat cycles after stb is first seen.
   always @(posedge clk) begin
      if (rst) begin
         ack_auto <= 1'b0;
         dat_auto <= '0;
         wcnt     <= 0;
      end else if (slave_auto && wbm_cyc_o && wbm_stb_o && !ack_auto) begin
         if (wcnt == slave_lat) begin
            ack_auto <= 1'b1;
            dat_auto <= wbm_we_o ? 32'h0 : rd_func(wbm_adr_o);
            wcnt     <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         ack_auto <= 1'b0;
         if (!wbm_cyc_o) wcnt <= 0;
      end
   end

   // Bus monitor: logs completed transfers and counts mid-cycle changes.
   always @(posedge clk) begin
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) bus_log.push_back(cur_bus);
      if (wbm_cyc_o !== wbm_stb_o) stab_viol <= stab_viol + 1;
      else if (prev_cyc && wbm_cyc_o && (cur_bus !== prev_bus)) stab_viol <= stab_viol + 1;
      prev_cyc <= wbm_cyc_o;
      prev_bus <= cur_bus;
   end

   task automatic drive_cmd(input logic we, input logic [3:0] sel,
                            input logic [31:0] adr, input logic [31:0] dat);
      cmd_we    = we;
      cmd_sel   = sel;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_valid = 1'b1;
   endtask

   task automatic drain_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 71'h0) begin
         errors++;
         $display("FAIL reset_wbm: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, expected all 0",
                  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat} !== 34'h0) begin
         errors++;
         $display("FAIL reset_rsp: got valid=%b err=%b dat=%h, expected 0", rsp_valid, rsp_err, rsp_dat);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({cmd_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL reset_idle: got cmd_ready=%b busy=%b, expected 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_write();
      drive_cmd(1'b1, 4'h1, 32'h3000_0000, 32'h0000_00A5);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_accept: got cmd_ready=%b, expected 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !==
             {1'b1, 1'b1, 1'b1, 4'h1, 32'h3000_0000, 32'h0000_00A5}) begin
            errors++;
            $display("FAIL wr_bus_c%0d: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, expected 1 1 1 1 30000000 000000a5",
                     i, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
         end
         if (i == 1) ack_man = 1'b1;
         @(negedge clk);
      end
      ack_man = 1'b0;
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 71'h0) begin
         errors++;
         $display("FAIL wr_bus_end: got cyc=%b stb=%b adr=%h, expected bus idle", wbm_cyc_o, wbm_stb_o, wbm_adr_o);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat, busy, cmd_ready} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL wr_rsp: got valid=%b err=%b dat=%h busy=%b ready=%b, expected 1 0 0 1 0",
                  rsp_valid, rsp_err, rsp_dat, busy, cmd_ready);
      end
      drain_rsp();
      checks++;
      if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
         errors++;
         $display("FAIL wr_done: got valid=%b busy=%b ready=%b, expected 0 0 1", rsp_valid, busy, cmd_ready);
      end
   endtask

   task automatic test_read();
      drive_cmd(1'b0, 4'hF, 32'h3000_0000, 32'hDEAD_BEEF);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o} !== {1'b1, 1'b0, 32'h3000_0000, 32'h0}) begin
            errors++;
            $display("FAIL rd_bus_c%0d: got cyc=%b we=%b adr=%h dat_o=%h, expected 1 0 30000000 0",
                     i, wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o);
         end
         if (i == 1) begin
            ack_man = 1'b1;
            dat_man = 32'h0000_0042;
         end
         @(negedge clk);
      end
      ack_man = 1'b0;
      dat_man = 32'h0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat, wbm_cyc_o} !== {1'b1, 1'b0, 32'h0000_0042, 1'b0}) begin
         errors++;
         $display("FAIL rd_rsp: got valid=%b err=%b dat=%h cyc=%b, expected 1 0 00000042 0",
                  rsp_valid, rsp_err, rsp_dat, wbm_cyc_o);
      end
      drain_rsp();
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_a;
      int n;
      exp_a      = rd_func(32'h3000_0010);
      slave_auto = 1'b1;
      slave_lat  = 0;
      drive_cmd(1'b0, 4'hF, 32'h3000_0010, 32'h0);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_busy_ready: got cmd_ready=%b, expected 0", cmd_ready);
      end
      drive_cmd(1'b1, 4'h3, 32'h3000_0020, 32'h1111_2222);
      n = 1;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rsp_valid, rsp_err, rsp_dat, cmd_ready, busy} !== {1'b1, 1'b0, exp_a, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bp_hold_c%0d: got valid=%b err=%b dat=%h ready=%b busy=%b, expected 1 0 %h 0 1",
                     i, rsp_valid, rsp_err, rsp_dat, cmd_ready, busy, exp_a);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, cmd_ready, wbm_cyc_o} !== 3'b010) begin
         errors++;
         $display("FAIL bp_release: got valid=%b ready=%b cyc=%b, expected 0 1 0", rsp_valid, cmd_ready, wbm_cyc_o);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if ({wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !==
          {1'b1, 1'b1, 4'h3, 32'h3000_0020, 32'h1111_2222}) begin
         errors++;
         $display("FAIL bp_next_cmd: got cyc=%b we=%b sel=%h adr=%h dat=%h, expected 1 1 3 30000020 11112222",
                  wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
      end
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL bp_next_rsp: got valid=%b err=%b dat=%h, expected 1 0 0", rsp_valid, rsp_err, rsp_dat);
      end
      drain_rsp();
      slave_auto = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
`ifdef WBM_TIMEOUT_EN
      drive_cmd(1'b0, 4'hF, 32'h3000_0030, 32'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (wbm_cyc_o && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != int'(TMO)) begin
         errors++;
         $display("FAIL tmo_cyc_len: got %0d cycles, expected %0d", n, TMO);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL tmo_rsp: got valid=%b err=%b dat=%h, expected 1 1 0", rsp_valid, rsp_err, rsp_dat);
      end
      drain_rsp();
      drive_cmd(1'b0, 4'hF, 32'h3000_0034, 32'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (wbm_cyc_o && n < 100) begin
         n++;
         if (n == int'(TMO)) begin
            ack_man = 1'b1;
            dat_man = 32'hCAFE_0016;
         end
         @(negedge clk);
         ack_man = 1'b0;
      end
      checks++;
      if (n != int'(TMO)) begin
         errors++;
         $display("FAIL tmo_last_len: got %0d cycles, expected %0d", n, TMO);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'hCAFE_0016}) begin
         errors++;
         $display("FAIL tmo_last_ack: got valid=%b err=%b dat=%h, expected 1 0 cafe0016", rsp_valid, rsp_err, rsp_dat);
      end
      drain_rsp();
`else
      drive_cmd(1'b0, 4'hF, 32'h3000_0030, 32'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 300; i++) begin
         if (wbm_cyc_o && !rsp_valid) n++;
         @(negedge clk);
      end
      checks++;
      if (n != 300) begin
         errors++;
         $display("FAIL notmo_wait: got %0d waiting cycles, expected 300", n);
      end
      ack_man = 1'b1;
      dat_man = 32'hCAFE_0300;
      @(negedge clk);
      ack_man = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat, wbm_cyc_o} !== {1'b1, 1'b0, 32'hCAFE_0300, 1'b0}) begin
         errors++;
         $display("FAIL notmo_rsp: got valid=%b err=%b dat=%h cyc=%b, expected 1 0 cafe0300 0",
                  rsp_valid, rsp_err, rsp_dat, wbm_cyc_o);
      end
      drain_rsp();
`endif
      dat_man = 32'h0;
   endtask

   task automatic test_reset_mid_bus();
      drive_cmd(1'b1, 4'hF, 32'h3000_0040, 32'h5555_AAAA);
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (wbm_stb_o !== 1'b1) begin
         errors++;
         $display("FAIL rstbus_stb: got stb=%b, expected 1", wbm_stb_o);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, cmd_ready, busy} !==
          {71'h0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rstbus_clear: got cyc=%b stb=%b adr=%h dat=%h valid=%b ready=%b busy=%b, expected 0s, ready 1",
                  wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_dat_o, rsp_valid, cmd_ready, busy);
      end
      ack_man = 1'b1;
      @(negedge clk);
      ack_man = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rsp_valid, busy, wbm_cyc_o} !== 3'b000) begin
            errors++;
            $display("FAIL rstbus_late_ack_c%0d: got valid=%b busy=%b cyc=%b, expected 0 0 0",
                     i, rsp_valid, busy, wbm_cyc_o);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_spurious_ack();
      bus_log.delete();
      ack_man = 1'b1;
      @(negedge clk);
      ack_man = 1'b0;
      checks++;
      if ({busy, rsp_valid, wbm_cyc_o, cmd_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL spur_idle: got busy=%b valid=%b cyc=%b ready=%b, expected 0 0 0 1",
                  busy, rsp_valid, wbm_cyc_o, cmd_ready);
      end
      drive_cmd(1'b0, 4'hF, 32'h3000_0050, 32'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      ack_man = 1'b1;
      dat_man = 32'h0000_0077;
      @(negedge clk);
      ack_man = 1'b0;
      dat_man = 32'hBAD0_BAD0;
      checks++;
      if ({rsp_valid, rsp_dat} !== {1'b1, 32'h0000_0077}) begin
         errors++;
         $display("FAIL spur_first_rsp: got valid=%b dat=%h, expected 1 00000077", rsp_valid, rsp_dat);
      end
      ack_man = 1'b1;
      repeat (2) @(negedge clk);
      ack_man = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat, busy, wbm_cyc_o, cmd_ready} !== {1'b1, 1'b0, 32'h0000_0077, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL spur_resp: got valid=%b err=%b dat=%h busy=%b cyc=%b ready=%b, expected 1 0 00000077 1 0 0",
                  rsp_valid, rsp_err, rsp_dat, busy, wbm_cyc_o, cmd_ready);
      end
      drain_rsp();
      dat_man = 32'h0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL spur_extra_rsp_c%0d: got valid=%b busy=%b, expected 0 0", i, rsp_valid, busy);
         end
         @(negedge clk);
      end
      checks++;
      if (bus_log.size() != 1) begin
         errors++;
         $display("FAIL spur_bus_count: got %0d transfers, expected 1", bus_log.size());
      end
   endtask

   task automatic test_random();
      slave_auto = 1'b1;
      bus_log.delete();
      for (int t = 0; t < 40; t++) begin
         logic        we;
         logic [3:0]  sel;
         logic [31:0] adr, dat, exp_rsp;
         bus_t        exp_bus;
         int          lat, stall, gap, n;
         we    = 1'($urandom_range(0, 1));
         sel   = 4'($urandom);
         adr   = $urandom;
         dat   = $urandom;
         lat   = int'($urandom_range(0, 4));
         stall = int'($urandom_range(0, 3));
         gap   = int'($urandom_range(0, 2));
         // Reference: one transfer per command, reads return slave data, writes 0.
         exp_rsp = we ? 32'h0 : rd_func(adr);
         exp_bus = {we, sel, adr, (we ? dat : 32'h0)};
         slave_lat = lat;
         repeat (gap) @(negedge clk);
         drive_cmd(we, sel, adr, dat);
         checks++;
         if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand_ready_t%0d: got cmd_ready=%b, expected 1", t, cmd_ready);
         end
         @(negedge clk);
         cmd_valid = 1'b0;
         n = 1;
         while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n != 3 + lat) begin
            errors++;
            $display("FAIL rand_latency_t%0d: got %0d cycles, expected %0d", t, n, 3 + lat);
         end
         for (int s = 0; s <= stall; s++) begin
            checks++;
            if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, exp_rsp}) begin
               errors++;
               $display("FAIL rand_rsp_t%0d_s%0d: got valid=%b err=%b dat=%h, expected 1 0 %h",
                        t, s, rsp_valid, rsp_err, rsp_dat, exp_rsp);
            end
            if (s < stall) @(negedge clk);
         end
         drain_rsp();
         checks++;
         if (bus_log.size() != 1 || bus_log[0] !== exp_bus) begin
            errors++;
            $display("FAIL rand_bus_t%0d: got %0d transfers first=%h, expected 1 transfer %h",
                     t, bus_log.size(), (bus_log.size() != 0) ? bus_log[0] : '0, exp_bus);
         end
         bus_log.delete();
      end
      checks++;
      if (stab_viol != 0) begin
         errors++;
         $display("FAIL bus_stability: got %0d violations, expected 0", stab_viol);
      end
      slave_auto = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_we     = 1'b0;
      cmd_sel    = '0;
      cmd_adr    = '0;
      cmd_dat    = '0;
      rsp_ready  = 1'b0;
      ack_man    = 1'b0;
      dat_man    = '0;
      slave_auto = 1'b0;
      slave_lat  = 0;
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_timeout();
      test_reset_mid_bus();
      test_spurious_ack();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
- Wishbone classic single-transfer initiator (master) for the user area.
- Turns a simple valid/ready command stream into one Wishbone read or write per command, and returns read data and status on a valid/ready response stream.
- Drives on-chip Wishbone slaves such as the user-project counter peripheral from local control logic or an LA-driven sequencer.
- The FSM is compatible with slaves that register ack one cycle after stb and guard on "valid && !ready".

Parameters:
- AW, 32, address width of cmd_adr / wbm_adr_o.
- DW, 32, data width of cmd_dat / rsp_dat / wbm_dat_*; byte-select width is DW/8.
- TIMEOUT_CYCLES, 255, bus cycles to wait for ack before aborting (only with WBM_TIMEOUT_EN; legal range 1..65535).

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  DW/8  byte selects.
- cmd_adr  in  AW  target address.
- cmd_dat  in  DW  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_dat  out  DW  read data (0 for writes and errors).
- rsp_err  out  1  1 = transfer aborted by timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  DW/8  Wishbone byte selects.
- wbm_adr_o  out  AW  Wishbone address.
- wbm_dat_o  out  DW  Wishbone write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  DW  slave read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, BUS, RESP. Reset: state = IDLE.
- Reset values: all registered outputs are 0 (wbm_*, rsp_valid, rsp_dat, rsp_err, timeout counter).
- cmd_ready = (state == IDLE), combinational. busy = (state != IDLE).
- IDLE: on cmd_valid && cmd_ready at edge N:
  - register we, sel, adr, and dat (dat forced to 0 for reads) onto wbm_*;
  - set cyc = stb = 1, visible in cycle N+1;
  - go to BUS.
- BUS: cyc/stb held high, outputs stable.
  - On the first edge where wbm_ack_i = 1: cyc = stb = 0 from the next cycle.
  - rsp_dat = wbm_dat_i for reads, 0 for writes; rsp_err = 0; rsp_valid = 1; go to RESP.
  - Minimum turnaround with a 1-cycle registered slave: accept at N, stb at N+1, ack sampled at N+2, rsp_valid at N+3.
- RESP: rsp_valid, rsp_dat and rsp_err are held stable until rsp_valid && rsp_ready at an edge.
  - At that edge: rsp_valid = 0; go to IDLE.
  - No new command is accepted until IDLE; at most one transfer is outstanding.
- Each accepted command produces exactly one bus cycle and exactly one response.
- wbm_ack_i is ignored in IDLE and RESP; spurious acks cause no state change.
- wbm_* outputs return to 0 when the bus cycle ends. They never change mid-cycle.
- Synchronous reset in any state, including BUS with stb high:
  - next edge forces IDLE and all outputs to 0;
  - the in-flight command is dropped and no response is issued.

Optional Feature:
- Macro: WBM_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUS and increments each BUS cycle without ack.
  - If no ack is sampled within TIMEOUT_CYCLES BUS cycles (i.e. cyc is high for TIMEOUT_CYCLES cycles): cyc/stb drop next cycle; go to RESP with rsp_err = 1 and rsp_dat = 0.
  - An ack on the final allowed cycle wins: normal response, rsp_err = 0.
- Undefined: no counter; BUS waits indefinitely for ack; rsp_err is tied to 0.

Test Plan:
- Write: cmd we=1 adr=0x3000_0000 dat=0x0000_00A5 sel=0x1; slave acks 1 cycle after stb -> wbm_cyc_o/stb_o high exactly 2 cycles with adr/dat/sel/we stable; one rsp with rsp_err=0 and rsp_dat=0.
- Read: cmd we=0 adr=0x3000_0000; slave returns 0x0000_0042 with ack -> rsp_dat=0x0000_0042, rsp_err=0; wbm_dat_o=0 during the cycle.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid, with cmd_valid held high -> rsp held stable, cmd_ready=0, busy=1; rsp_ready=1 -> next command accepted one cycle later.
- Timeout (WBM_TIMEOUT_EN, TIMEOUT_CYCLES=16), slave never acks -> cyc high exactly 16 cycles, then rsp_err=1 and rsp_dat=0. Repeat with ack on cycle 16 -> rsp_err=0 with data.
- Reset mid-BUS: assert wb_rst_i for 1 cycle while stb is high -> next cycle all wbm_* outputs and rsp_valid are 0, state is IDLE; a later ack is ignored and no response appears.
- Spurious ack: pulse wbm_ack_i in IDLE and in RESP -> no state change, no extra response; next command completes normally.
